gpio_apb_ctrl: RTL and testbench

APB3 register-side controller for the GPIO pad bank. It owns the direction and output-data registers that drive the pad wrapper's `DIR`/`WDATA` inputs, and it synchronises the wrapper's `RDATA` back into the clock domain. It also detects per-pin edges into a sticky interrupt status and raises a single level interrupt to the Cortex-M3 NVIC. It sits on the peripheral APB segment, between the AHB-to-APB bridge and the pad wrapper.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_sync_edge.sv | 37 +++
 rtl/gpio_apb_ctrl.sv | 129 ++++++++++++
 tb/tb_gpio_apb_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the APB GPIO controller.
// Register byte offsets, address decode limit and edge polarity codes.
package gpio_pkg;

    localparam logic [11:0] GPIO_OFS_DOUT    = 12'h000;
    localparam logic [11:0] GPIO_OFS_DIR     = 12'h004;
    localparam logic [11:0] GPIO_OFS_DIN     = 12'h008;
    localparam logic [11:0] GPIO_OFS_INTEN   = 12'h00C;
    localparam logic [11:0] GPIO_OFS_INTPOL  = 12'h010;
    localparam logic [11:0] GPIO_OFS_INTSTAT = 12'h014;
    localparam logic [11:0] GPIO_OFS_DSET    = 12'h018;
    localparam logic [11:0] GPIO_OFS_DCLR    = 12'h01C;

    // Highest decoded address bit; everything above must be zero.
    localparam int GPIO_ADDR_MSB = 4;

    localparam logic GPIO_POL_RISE = 1'b0;
    localparam logic GPIO_POL_FALL = 1'b1;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: 2-flop pin synchroniser, history flop and edge detect.
// Ports: i_clk/i_rst, i_pin (async), i_dir (1=output), o_sync, o_rise, o_fall.
module gpio_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pin,
    input  logic [WIDTH-1:0] i_dir,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;

    // History is forced low on output pins so a later switch back to
    // input never sees a stale high and fakes a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2 & ~i_dir;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_prev;
    assign o_fall = ~r_s2 & r_prev;

endmodule

// File: rtl/gpio_apb_ctrl.sv
// gpio_apb_ctrl: APB3 register block for the GPIO pad bank with edge IRQ.
// Ports: APB slave (PCLK, PRESET, PSEL..PSLVERR), pad DIR/WDATA/RDATA, IRQ.
module gpio_apb_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [11:0]           PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [GPIO_WIDTH-1:0] GPIO_DIR,
    output logic [GPIO_WIDTH-1:0] GPIO_WDATA,
    input  logic [GPIO_WIDTH-1:0] GPIO_RDATA,
    output logic                  IRQ
);

    logic [GPIO_WIDTH-1:0] r_dout;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_inten;
    logic [GPIO_WIDTH-1:0] r_intpol;
    logic [GPIO_WIDTH-1:0] r_intstat;
    logic [31:0]           r_prdata;
    logic                  r_irq;

    logic                  w_hit;
    logic [11:0]           w_ofs;
    logic                  w_wr;
    logic                  w_rd;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_event;
    logic [GPIO_WIDTH-1:0] w_rdval;
    logic [31:0]           w_rdword;
    logic                  w_unused;

    gpio_sync_edge #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .i_clk  (PCLK),
        .i_rst  (PRESET),
        .i_pin  (GPIO_RDATA),
        .i_dir  (r_dir),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_hit   = (PADDR[11:GPIO_ADDR_MSB+1] == '0);
    assign w_ofs   = {7'd0, PADDR[GPIO_ADDR_MSB:2], 2'b00};
    assign w_wr    = PSEL & PENABLE & PWRITE & w_hit;
    assign w_rd    = PSEL & ~PENABLE & ~PWRITE;
    assign w_wdata = PWDATA[GPIO_WIDTH-1:0];
    assign w_w1c   = (w_wr && w_ofs == GPIO_OFS_INTSTAT) ? w_wdata : '0;
    assign w_unused = ^{PADDR[1:0], PWDATA};

    always_comb begin
        w_event = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            w_event[i] = (r_intpol[i] == GPIO_POL_FALL) ? w_fall[i]
                                                        : w_rise[i];
        end
        w_event = w_event & ~r_dir;
    end

    always_comb begin
        w_rdval = '0;
        if (w_hit) begin
            unique case (w_ofs)
                GPIO_OFS_DOUT:    w_rdval = r_dout;
                GPIO_OFS_DIR:     w_rdval = r_dir;
                GPIO_OFS_DIN:     w_rdval = w_sync;
                GPIO_OFS_INTEN:   w_rdval = r_inten;
                GPIO_OFS_INTPOL:  w_rdval = r_intpol;
                GPIO_OFS_INTSTAT: w_rdval = r_intstat;
                default:          w_rdval = '0;
            endcase
        end
        w_rdword = '0;
        w_rdword[GPIO_WIDTH-1:0] = w_rdval;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_dout    <= '0;
            r_dir     <= '0;
            r_inten   <= '0;
            r_intpol  <= '0;
            r_intstat <= '0;
            r_prdata  <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr) begin
                unique case (w_ofs)
                    GPIO_OFS_DOUT:   r_dout   <= w_wdata;
                    GPIO_OFS_DIR:    r_dir    <= w_wdata;
                    GPIO_OFS_INTEN:  r_inten  <= w_wdata;
                    GPIO_OFS_INTPOL: r_intpol <= w_wdata;
                    GPIO_OFS_DSET:   r_dout   <= r_dout | w_wdata;
                    GPIO_OFS_DCLR:   r_dout   <= r_dout & ~w_wdata;
                    default:         ;
                endcase
            end
            // A same-cycle event overrides the W1C for that bit.
            r_intstat <= (r_intstat & ~w_w1c) | w_event;
            if (w_rd) begin
                r_prdata <= w_rdword;
            end
            r_irq <= |(r_intstat & r_inten);
        end
    end

    assign PRDATA     = r_prdata;
    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign GPIO_DIR   = r_dir;
    assign GPIO_WDATA = r_dout;
    assign IRQ        = r_irq;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// tb_gpio_apb_ctrl: directed bench for gpio_apb_ctrl with a cycle model.
// Drives APB and pin stimulus on negedge, compares outputs on negedge.
module tb_gpio_apb_ctrl;

    localparam int W = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [11:0]   PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [W-1:0]  GPIO_DIR;
    logic [W-1:0]  GPIO_WDATA;
    logic [W-1:0]  GPIO_RDATA;
    logic          IRQ;

    int checks = 0;
    int errors = 0;

    gpio_apb_ctrl #(.GPIO_WIDTH(W)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .GPIO_DIR   (GPIO_DIR),
        .GPIO_WDATA (GPIO_WDATA),
        .GPIO_RDATA (GPIO_RDATA),
        .IRQ        (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: registers by name, pin samples kept per edge so
    // DIN is "pin two edges ago" and an edge is a change between the
    // samples two and three edges back.
    logic [W-1:0] m_dout, m_dir, m_inten, m_intpol, m_intstat;
    logic [31:0]  m_prdata;
    logic         m_irq;
    logic         m_valid = 1'b0;
    logic [W-1:0] pin_s [0:7];
    logic [W-1:0] dir_s [0:7];
    int           cyc = 8;

    initial begin
        for (int i = 0; i < 8; i++) begin
            pin_s[i] = '0;
            dir_s[i] = '0;
        end
    end

    always @(posedge PCLK) begin : model
        logic [W-1:0] cur, old, ev, wv, w1c;
        logic         hit, irq_n;
        logic [2:0]   ofs;
        logic [31:0]  rv;
        dir_s[cyc % 8] = m_dir;
        pin_s[cyc % 8] = PRESET ? '0 : GPIO_RDATA;
        if (PRESET) begin
            m_dout = '0; m_dir = '0; m_inten = '0; m_intpol = '0;
            m_intstat = '0; m_prdata = '0; m_irq = 1'b0;
            m_valid = 1'b1;
        end else begin
            cur = pin_s[(cyc - 2) % 8];
            old = pin_s[(cyc - 3) % 8] & ~dir_s[(cyc - 1) % 8];
            ev  = ((cur & ~old & ~m_intpol) | (~cur & old & m_intpol))
                  & ~m_dir;
            wv  = PWDATA[W-1:0];
            hit = (PADDR[11:5] == 7'd0);
            ofs = PADDR[4:2];
            irq_n = |(m_intstat & m_inten);
            if (PSEL && !PENABLE && !PWRITE) begin
                rv = '0;
                if (hit) begin
                    case (ofs)
                        3'd0: rv[W-1:0] = m_dout;
                        3'd1: rv[W-1:0] = m_dir;
                        3'd2: rv[W-1:0] = cur;
                        3'd3: rv[W-1:0] = m_inten;
                        3'd4: rv[W-1:0] = m_intpol;
                        3'd5: rv[W-1:0] = m_intstat;
                        default: rv = '0;
                    endcase
                end
                m_prdata = rv;
            end
            w1c = '0;
            if (PSEL && PENABLE && PWRITE && hit) begin
                case (ofs)
                    3'd0: m_dout = wv;
                    3'd1: m_dir = wv;
                    3'd3: m_inten = wv;
                    3'd4: m_intpol = wv;
                    3'd5: w1c = wv;
                    3'd6: m_dout = m_dout | wv;
                    3'd7: m_dout = m_dout & ~wv;
                    default: ;
                endcase
            end
            m_intstat = (m_intstat & ~w1c) | ev;
            m_irq = irq_n;
        end
        cyc++;
    end

    always @(negedge PCLK) begin
        if (m_valid) begin
            chk("gpio_dir", 32'(GPIO_DIR), 32'(m_dir));
            chk("gpio_wdata", 32'(GPIO_WDATA), 32'(m_dout));
            chk("irq", 32'(IRQ), 32'(m_irq));
            chk("prdata", PRDATA, m_prdata);
            chk("pready", 32'(PREADY), 32'd1);
            chk("pslverr", 32'(PSLVERR), 32'd0);
        end
    end

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a,
                          input logic [31:0] e);
        logic [31:0] d;
        apb_read(a, d);
        chk(nm, d, e);
    endtask

    task automatic pins(input logic [W-1:0] v, input int wait_cyc);
        @(negedge PCLK);
        GPIO_RDATA = v;
        repeat (wait_cyc) @(negedge PCLK);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; GPIO_RDATA = '0;
        repeat (4) @(negedge PCLK);
        PRESET = 1'b0;

        for (int i = 0; i < 8; i++) rd_chk("reset_read", 12'(i * 4), 32'd0);
        chk("reset_dir", 32'(GPIO_DIR), 32'd0);
        chk("reset_irq", 32'(IRQ), 32'd0);

        apb_write(12'h004, 32'h0000_00FF);
        apb_write(12'h000, 32'hDEAD_00A5);
        chk("dout_commit", 32'(GPIO_WDATA), 32'h0000_00A5);
        rd_chk("dout_width", 12'h000, 32'h0000_00A5);
        apb_write(12'h018, 32'h0000_0100);
        apb_write(12'h01C, 32'h0000_0005);
        rd_chk("dset_dclr", 12'h000, 32'h0000_01A0);
        rd_chk("dset_reads0", 12'h018, 32'd0);
        chk("pad_out", 32'(GPIO_WDATA), 32'h0000_01A0);

        apb_write(12'h004, 32'd0);
        apb_write(12'h00C, 32'h0000_0008);
        apb_write(12'h010, 32'd0);
        pins(16'h0008, 3);
        chk("irq_before_k3", 32'(IRQ), 32'd0);
        @(negedge PCLK);
        chk("irq_at_k3", 32'(IRQ), 32'd1);
        rd_chk("din_bit3", 12'h008, 32'h0000_0008);
        rd_chk("intstat_rise", 12'h014, 32'h0000_0008);

        apb_write(12'h014, 32'h0000_0008);
        chk("irq_hold_after_w1c", 32'(IRQ), 32'd1);
        @(negedge PCLK);
        chk("irq_drop_after_w1c", 32'(IRQ), 32'd0);
        rd_chk("intstat_cleared", 12'h014, 32'd0);

        pins(16'h0000, 6);
        @(negedge PCLK);
        GPIO_RDATA = 16'h0008;
        apb_write(12'h014, 32'h0000_0008);
        rd_chk("set_beats_clear", 12'h014, 32'h0000_0008);
        apb_write(12'h014, 32'h0000_0008);

        apb_write(12'h010, 32'h0000_0020);
        apb_write(12'h00C, 32'h0000_0028);
        pins(16'h0028, 6);
        rd_chk("rise_ignored_pol1", 12'h014, 32'd0);
        pins(16'h0008, 6);
        rd_chk("fall_sets", 12'h014, 32'h0000_0020);
        chk("irq_fall", 32'(IRQ), 32'd1);
        apb_write(12'h014, 32'h0000_0020);

        apb_write(12'h004, 32'h0000_0001);
        apb_write(12'h00C, 32'h0000_0029);
        pins(16'h0009, 6);
        pins(16'h0008, 6);
        rd_chk("output_masked", 12'h014, 32'd0);
        pins(16'h0009, 6);
        rd_chk("output_high_masked", 12'h014, 32'd0);
        apb_write(12'h004, 32'd0);
        repeat (4) @(negedge PCLK);
        rd_chk("dir_switch_rise", 12'h014, 32'h0000_0001);
        apb_write(12'h014, 32'h0000_0001);
        pins(16'h0008, 6);

        rd_chk("inten_rb", 12'h00C, 32'h0000_0029);
        rd_chk("unmapped_read", 12'h020, 32'd0);
        apb_write(12'h020, 32'h0000_FFFF);
        apb_write(12'h008, 32'h0000_FFFF);
        rd_chk("unmapped_wr_dout", 12'h000, 32'h0000_01A0);
        rd_chk("unmapped_wr_dir", 12'h004, 32'd0);
        rd_chk("unmapped_wr_inten", 12'h00C, 32'h0000_0029);
        rd_chk("unmapped_wr_intpol", 12'h010, 32'h0000_0020);

        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 12'h000; PWDATA = 32'h0000_FFFF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        PRESET = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("abort_wdata", 32'(GPIO_WDATA), 32'd0);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);
        rd_chk("abort_dout", 12'h000, 32'd0);
        rd_chk("release_high_pin", 12'h014, 32'h0000_0008);
        chk("release_irq", 32'(IRQ), 32'd0);

        repeat (2) @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
